// File: rtl/mcdf_formatter.sv
// rtl/mcdf_formatter.sv - round-robin packet formatter draining three channel FIFOs
module mcdf_formatter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [2:0]             ch_rd_en,
  input  logic [3*WIDTH-1:0]     ch_data,
  input  logic [2:0]             ch_empty,
  input  logic [3*(DEPTH+1)-1:0] ch_margin,
  input  logic [2:0]             cfg_en,
  input  logic [5:0]             cfg_len,
  output logic                   fmt_req,
  input  logic                   fmt_grant,
  output logic [1:0]             fmt_chid,
  output logic [5:0]             fmt_length,
  output logic                   fmt_valid,
  output logic [WIDTH-1:0]       fmt_data,
  output logic                   fmt_start,
  output logic                   fmt_end
);
  typedef enum logic [1:0] {IDLE, REQ, SEND, DRAIN} state_t;

  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};

  state_t         state, state_nxt;
  logic [1:0]     rr, win, c1, c2;
  logic [DEPTH:0] occ [3];
  logic [2:0]     elig;
  logic           any_elig;
  logic [5:0]     rd_cnt;
  logic           rd, last_rd, start_q, end_q;

  function automatic logic [5:0] dec_len(input logic [1:0] code);
    return 6'd4 << code;
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Margin of exactly CAP wraps to occupancy 0 in DEPTH+1 bits.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      occ[i]  = CAP - ch_margin[i*(DEPTH+1) +: DEPTH+1];
      elig[i] = cfg_en[i] && (32'(occ[i]) >= 32'(dec_len(cfg_len[2*i +: 2])));
    end
  end

  assign c1       = inc3(rr);
  assign c2       = inc3(c1);
  assign any_elig = |elig;

  // Later assignments win, so the channel nearest rr takes priority.
  always_comb begin
    win = rr;
    if (elig[c2]) win = c2;
    if (elig[c1]) win = c1;
    if (elig[rr]) win = rr;
  end

  assign rd      = (state == SEND) && !ch_empty[fmt_chid] && (rd_cnt < fmt_length);
  assign last_rd = rd && (rd_cnt == fmt_length - 6'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = REQ;
      REQ:     if (fmt_grant) state_nxt = SEND;
      SEND:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= 2'd0;
      fmt_chid   <= 2'd0;
      fmt_length <= 6'd0;
      rd_cnt     <= 6'd0;
      fmt_valid  <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fmt_valid <= rd;
      start_q   <= rd && (rd_cnt == 6'd0);
      end_q     <= last_rd;
      if (state == IDLE && any_elig) begin
        fmt_chid   <= win;
        fmt_length <= dec_len(cfg_len[2*win +: 2]);
        rr         <= inc3(win);
        rd_cnt     <= 6'd0;
      end else if (rd) begin
        rd_cnt <= rd_cnt + 6'd1;
      end
    end
  end

  assign ch_rd_en  = rd ? (3'b001 << fmt_chid) : 3'b000;
  assign fmt_req   = (state == REQ);
  assign fmt_data  = fmt_valid ? ch_data[fmt_chid*WIDTH +: WIDTH] : '0;
  assign fmt_start = fmt_valid && start_q;
  assign fmt_end   = fmt_valid && end_q;
endmodule

// File: tb/tb_mcdf_formatter.sv
// tb/tb_mcdf_formatter.sv - scoreboard bench for mcdf_formatter
module tb_mcdf_formatter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [2:0]             ch_rd_en;
  logic [3*WIDTH-1:0]     ch_data;
  logic [2:0]             ch_empty;
  logic [3*(DEPTH+1)-1:0] ch_margin;
  logic [2:0]             cfg_en;
  logic [5:0]             cfg_len;
  logic                   fmt_req, fmt_grant;
  logic [1:0]             fmt_chid;
  logic [5:0]             fmt_length;
  logic                   fmt_valid;
  logic [WIDTH-1:0]       fmt_data;
  logic                   fmt_start, fmt_end;

  mcdf_formatter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ch_rd_en(ch_rd_en), .ch_data(ch_data),
    .ch_empty(ch_empty), .ch_margin(ch_margin), .cfg_en(cfg_en), .cfg_len(cfg_len),
    .fmt_req(fmt_req), .fmt_grant(fmt_grant), .fmt_chid(fmt_chid),
    .fmt_length(fmt_length), .fmt_valid(fmt_valid), .fmt_data(fmt_data),
    .fmt_start(fmt_start), .fmt_end(fmt_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       chid;
    logic [WIDTH-1:0] data;
    logic             st;
    logic             en;
  } exp_t;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               first_cyc = 0;
  int               last_cyc = 0;
  int               gcyc = 0;
  exp_t             exp_q[$];
  logic [WIDTH-1:0] fifo [3][$];
  logic [2:0]       empty_r = 3'b111;
  logic [2:0]       force_empty = 3'b000;
  logic [2:0]       rd_s = 3'b000;

  assign ch_empty = empty_r | force_empty;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic update_flags();
    for (int i = 0; i < 3; i++) begin
      empty_r[i] = (fifo[i].size() == 0);
      ch_margin[i*(DEPTH+1) +: DEPTH+1] = 7'(64 - fifo[i].size());
    end
  endtask

  task automatic wr(input int c, input logic [WIDTH-1:0] w);
    fifo[c].push_back(w);
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 3; i++) fifo[i].delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: reads pop at the edge, status (including earlier writes) is visible a cycle later.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rd_s[i]) begin
        if (fifo[i].size() > 0) ch_data[i*WIDTH +: WIDTH] = fifo[i].pop_front();
        else check("read_of_empty_fifo", 64'(i), 64'(99));
      end
    end
    update_flags();
  end

  // Monitor: compares every presented word against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    rd_s = ch_rd_en;
    if (rst_n) begin
      if (ch_rd_en != 3'b000)
        check("rd_only_chid", 64'(ch_rd_en & ~(3'b001 << fmt_chid)), 64'(0));
      if (fmt_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(fmt_data), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(fmt_data), 64'(e.data));
          check("word_chid", 64'(fmt_chid), 64'(e.chid));
          check("word_start", 64'(fmt_start), 64'(e.st));
          check("word_end", 64'(fmt_end), 64'(e.en));
          if (fmt_start) first_cyc = cyc;
          if (fmt_end) last_cyc = cyc;
        end
      end else begin
        check("data_zero_idle", 64'(fmt_data), 64'(0));
      end
    end
  end

  task automatic run_pkt(input int exp_ch, input int exp_len, input int gdelay);
    int         t;
    logic [1:0] c0;
    logic [5:0] l0;
    exp_t       e;
    t = 0;
    while (!fmt_req && t < 60) begin
      step();
      t++;
    end
    check("req_seen", 64'(fmt_req), 64'(1));
    check("pkt_chid", 64'(fmt_chid), 64'(exp_ch));
    check("pkt_length", 64'(fmt_length), 64'(exp_len));
    c0 = fmt_chid;
    l0 = fmt_length;
    for (int k = 0; k < exp_len; k++) begin
      e.chid = 2'(exp_ch);
      e.data = fifo[exp_ch][k];
      e.st   = (k == 0);
      e.en   = (k == exp_len - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < gdelay; k++) begin
      step();
      check("req_hold", 64'(fmt_req), 64'(1));
      check("no_rd_before_grant", 64'(ch_rd_en), 64'(0));
      check("chid_stable", 64'(fmt_chid), 64'(c0));
      check("length_stable", 64'(fmt_length), 64'(l0));
    end
    fmt_grant = 1'b1;
    gcyc = cyc;
    step();
    fmt_grant = 1'b0;
    check("req_drop_after_grant", 64'(fmt_req), 64'(0));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check("pkt_complete", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    fmt_grant = 1'b0;
    cfg_en    = 3'b000;
    cfg_len   = 6'b000000;
    ch_data   = '0;
    update_flags();
    repeat (3) step();
    check("rst_req", 64'(fmt_req), 64'(0));
    check("rst_rd_en", 64'(ch_rd_en), 64'(0));
    check("rst_valid", 64'(fmt_valid), 64'(0));
    check("rst_chid", 64'(fmt_chid), 64'(0));
    check("rst_length", 64'(fmt_length), 64'(0));
    check("rst_data", 64'(fmt_data), 64'(0));
    rst_n = 1'b1;
    step();

    // Single 4-word packet on ch0, grant one cycle after request
    for (int k = 0; k < 4; k++) wr(0, 32'hA000_0000 + 32'(k));
    cfg_en = 3'b001;
    run_pkt(0, 4, 1);
    wait_done();
    check("t1_first_valid_cycle", 64'(first_cyc), 64'(gcyc + 2));
    check("t1_last_valid_cycle", 64'(last_cyc), 64'(gcyc + 5));

    // Threshold: ch1 with length 8, config changed after request entry
    cfg_en  = 3'b010;
    cfg_len = 6'b000100;
    for (int k = 0; k < 7; k++) wr(1, 32'hB100_0000 + 32'(k));
    repeat (5) step();
    check("t2_no_req_at_7", 64'(fmt_req), 64'(0));
    wr(1, 32'hB100_0007);
    step();
    check("t2_no_req_next_cycle", 64'(fmt_req), 64'(0));
    step();
    check("t2_req_second_cycle", 64'(fmt_req), 64'(1));
    cfg_en  = 3'b000;
    cfg_len = 6'b000000;
    run_pkt(1, 8, 0);
    wait_done();

    // Grant withheld for 10 cycles on ch2
    for (int k = 0; k < 4; k++) wr(2, 32'hC200_0000 + 32'(k));
    cfg_en = 3'b100;
    run_pkt(2, 4, 10);
    wait_done();

    // Empty stall of 2 cycles mid-packet on ch0
    for (int k = 0; k < 4; k++) wr(0, 32'hD000_0000 + 32'(k));
    cfg_en = 3'b001;
    run_pkt(0, 4, 0);
    step();
    force_empty = 3'b001;
    step();
    step();
    force_empty = 3'b000;
    wait_done();
    check("t4_stall_span", 64'(last_cyc - first_cyc), 64'(5));

    // Round-robin from rr=0 after a reset
    cfg_en = 3'b000;
    rst_n  = 1'b0;
    clear_fifos();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) wr(0, 32'hE000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) wr(1, 32'hE100_0000 + 32'(k));
    for (int k = 0; k < 4; k++) wr(2, 32'hE200_0000 + 32'(k));
    step();
    cfg_en = 3'b111;
    run_pkt(0, 4, 0);
    wait_done();
    run_pkt(1, 4, 0);
    wait_done();
    run_pkt(2, 4, 0);
    wait_done();
    run_pkt(0, 4, 0);
    wait_done();

    // Reset mid-SEND: rr is 1 here, so ch1 wins first
    cfg_en = 3'b000;
    for (int k = 0; k < 4; k++) wr(0, 32'hF000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) wr(1, 32'hF100_0000 + 32'(k));
    step();
    cfg_en = 3'b011;
    run_pkt(1, 4, 0);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 64'(ch_rd_en), 64'(0));
    check("mid_rst_req", 64'(fmt_req), 64'(0));
    check("mid_rst_valid", 64'(fmt_valid), 64'(0));
    check("mid_rst_data", 64'(fmt_data), 64'(0));
    check("mid_rst_start_end", 64'({fmt_start, fmt_end}), 64'(0));
    check("mid_rst_chid_len", 64'({fmt_chid, fmt_length}), 64'(0));
    exp_q.delete();
    clear_fifos();
    for (int k = 0; k < 4; k++) wr(0, 32'h1000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) wr(1, 32'h1100_0000 + 32'(k));
    step();
    step();
    rst_n = 1'b1;
    run_pkt(0, 4, 0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
